// File: rtl/fifo_wr_arbiter.sv
// Two-requester FIFO write-port arbiter: round-robin on ties, bursts of up to BURST_LEN words per grant.
// Optional per-requester accepted-word counters are enabled by defining FIFO_ARB_CNT_EN.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    input  logic              full_flag,
    output logic              en_w,
    output logic [DATA_W-1:0] data_in,
    output logic [15:0]       cnt0,
    output logic [15:0]       cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        w_last_next;
    logic [3:0]  r_burst;
    logic [3:0]  w_burst_next;
    logic [3:0]  w_burst_inc;
    logic        w_in_gnt;
    logic        w_own;
    logic        w_req_own;
    logic        w_req_oth;
    logic        w_ack;
    logic        w_end;
    logic        w_ack0;
    logic        w_ack1;
    logic [DATA_W-1:0] w_data;

    // Requester-relative view of the current grant so both GNT states share one code path.
    always_comb begin
        w_in_gnt    = (r_state == GNT0) || (r_state == GNT1);
        w_own       = (r_state == GNT1);
        w_req_own   = w_own ? req1 : req0;
        w_req_oth   = w_own ? req0 : req1;
        w_ack       = w_in_gnt && w_req_own && !full_flag;
        w_burst_inc = r_burst + 4'd1;
        w_end       = !w_req_own || (w_ack && (w_burst_inc == BURST_MAX));
    end

    // Next-state, last-served and burst-count logic.
    always_comb begin
        w_next       = r_state;
        w_last_next  = r_last;
        w_burst_next = r_burst;
        case (r_state)
            IDLE: begin
                w_burst_next = 4'd0;
                if (req0 && !req1) begin
                    w_next = GNT0;
                end else if (req1 && !req0) begin
                    w_next = GNT1;
                end else if (req0 && req1) begin
                    w_next = r_last ? GNT0 : GNT1;
                end else begin
                    w_next = IDLE;
                end
            end
            GNT0, GNT1: begin
                // A full FIFO freezes the grant and burst count until space returns.
                if (full_flag) begin
                    w_next       = r_state;
                    w_burst_next = r_burst;
                end else if (w_end) begin
                    w_burst_next = 4'd0;
                    if (w_req_oth) begin
                        w_next      = w_own ? GNT0 : GNT1;
                        w_last_next = w_own;
                    end else if (w_req_own) begin
                        w_next = r_state;
                    end else begin
                        w_next      = IDLE;
                        w_last_next = w_own;
                    end
                end else if (w_ack) begin
                    w_burst_next = w_burst_inc;
                end else begin
                    w_burst_next = r_burst;
                end
            end
            default: begin
                w_next       = IDLE;
                w_burst_next = 4'd0;
            end
        endcase
    end

    // Per-requester write strobes and the muxed write data.
    always_comb begin
        w_ack0 = 1'b0;
        w_ack1 = 1'b0;
        w_data = '0;
        if (rst) begin
            w_ack0 = 1'b0;
            w_ack1 = 1'b0;
            w_data = '0;
        end else if (r_state == GNT0) begin
            w_ack0 = w_ack;
            w_data = data0;
        end else if (r_state == GNT1) begin
            w_ack1 = w_ack;
            w_data = data1;
        end else begin
            w_data = '0;
        end
    end

    // Outputs are forced low while reset is held so an aborted burst never writes.
    always_comb begin
        gnt0    = (r_state == GNT0) && !rst;
        gnt1    = (r_state == GNT1) && !rst;
        ack0    = w_ack0;
        ack1    = w_ack1;
        en_w    = w_ack0 || w_ack1;
        data_in = w_data;
    end

    // Arbiter state registers; requester 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_burst <= 4'd0;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
            r_burst <= w_burst_next;
        end
    end

`ifdef FIFO_ARB_CNT_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    // Accepted-word counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= 16'd0;
            r_cnt1 <= 16'd0;
        end else begin
            if (w_ack0) begin
                r_cnt0 <= r_cnt0 + 16'd1;
            end
            if (w_ack1) begin
                r_cnt1 <= r_cnt1 + 16'd1;
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`else
    assign cnt0 = 16'd0;
    assign cnt1 = 16'd0;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the write-data width in bits.
REQ-002 The module SHALL have parameter BURST_LEN, default 4, giving the maximum number of words accepted per grant (range 1..15).
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have ports req0 and req1, input, 1 bit each: requester has a word to write.
REQ-006 The module SHALL have ports data0 and data1, input, DATA_W bits each: requester write data, held stable while the matching req is high.
REQ-007 The module SHALL have ports gnt0 and gnt1, output, 1 bit each: requester owns the FIFO write port.
REQ-008 The module SHALL have ports ack0 and ack1, output, 1 bit each: the requester's word is written on this edge.
REQ-009 The module SHALL have port full_flag, input, 1 bit: FIFO full.
REQ-010 The module SHALL have port en_w, output, 1 bit: FIFO write enable.
REQ-011 The module SHALL have port data_in, output, DATA_W bits: FIFO write data.
REQ-012 The module SHALL have ports cnt0 and cnt1, output, 16 bits each: count of accepted words per requester.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GNT0 and GNT1; gntN SHALL be high only in state GNTN.
REQ-014 In GNTN, ackN and en_w SHALL be driven combinationally as reqN AND NOT full_flag; data_in SHALL equal dataN in GNTN and 0 otherwise.
REQ-015 With full_flag high, en_w and ack SHALL be low, and the grant and burst counter SHALL hold.
REQ-016 In IDLE, the arbiter SHALL move to GNT0 if only req0 is high, to GNT1 if only req1 is high, and otherwise to the requester not served last (register last).
REQ-017 Grant latency SHALL be one cycle: a req sampled in IDLE raises its gnt on the next cycle, and the first write can occur in that same cycle.
REQ-018 A burst counter SHALL increment on every ack and clear on every grant change or re-grant.
REQ-019 GNTN SHALL end when reqN is low, or when an ack brings the counter to BURST_LEN.
REQ-020 On end of GNTN, the arbiter SHALL go to the other GNT state if the other req is high, else re-grant GNTN with a cleared counter if reqN is high, else go to IDLE.
REQ-021 last SHALL update to N whenever GNTN is exited.
REQ-022 No cycle SHALL exist in which both gnt0 and gnt1 are high, or in which en_w is high with full_flag high.

Reset
REQ-023 While rst is high at a clock edge: state SHALL become IDLE, last SHALL become 1 (requester 0 wins the first tie), the burst counter SHALL become 0, and cnt0/cnt1 SHALL become 0.
REQ-024 While rst is high, gnt0, gnt1, ack0, ack1 and en_w SHALL be 0, and data_in SHALL be 0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no write on that edge.

Configuration
REQ-026 With macro FIFO_ARB_CNT_EN defined, cntN SHALL increment by 1 (wrapping at 16 bits) on every edge where ackN is high.
REQ-027 Without FIFO_ARB_CNT_EN defined, cnt0 and cnt1 SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-028 Single requester: req0=1 for 3 words (0xA,0xB,0xC), full_flag=0 -> gnt0 one cycle after req; en_w high 3 cycles; data_in sequence 0xA,0xB,0xC; back to IDLE.
REQ-029 Contention: req0=req1=1 continuously from reset, BURST_LEN=4 -> alternating bursts of exactly 4 writes, 0 first, then 1, then 0.
REQ-030 Backpressure: full_flag=1 for 3 cycles during GNT1 after 2 acks -> en_w/ack1 low for 3 cycles, gnt1 held, burst completes with 2 more acks.
REQ-031 Reset mid-burst: rst=1 after 2 acks of requester 1 -> next cycle all outputs 0, state IDLE; with both requesting after release, gnt0 wins.
REQ-032 Counters: 5 writes from requester 0 and 3 from requester 1 -> cnt0=5, cnt1=3 with FIFO_ARB_CNT_EN; both 0 without it.
REQ-033 Early release: req1 dropped after 1 ack while req0=1 -> GNT0 on the next cycle; last=1.
